// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// ------------
// 8N1 UART receiver feeding a small first-word-fall-through receive FIFO.
//
// Parameters:
//   FIFO_DEPTH  number of receive FIFO entries (power of two, >= 2)
//
// Ports:
//   clk        single clock, all state updates on the rising edge
//   reset      asynchronous, active-low reset
//   baud_div   clocks per serial bit (>= 4), captured at each start bit
//   rx_in      asynchronous serial line, idle high, LSB first
//   rx_data    byte at the FIFO head (0 while the FIFO is empty)
//   rx_valid   FIFO holds at least one byte
//   rx_latch   pop request, ignored while rx_valid is low
//   frame_err  one-cycle pulse when a stop bit is sampled low
//   overrun    one-cycle pulse when a received byte is dropped on a full FIFO

module uart_rx_fifo #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] baud_div,
    input  logic        rx_in,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_latch,
    output logic        frame_err,
    output logic        overrun
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t      state, state_n;
    logic        sync1, line;
    logic [15:0] cnt, cnt_n;
    logic [15:0] div_lat, div_lat_n;
    logic [2:0]  bit_cnt, bit_cnt_n;
    logic [7:0]  shreg, shreg_n;
    logic        expire;
    logic        push_req;
    logic        ferr_req;

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        empty, full, pop, push_ok, ovr_req;

    // Two-flop synchronizer; resets to the idle level so that reset release
    // can never be mistaken for a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b1;
            line  <= 1'b1;
        end else begin
            sync1 <= rx_in;
            line  <= sync1;
        end
    end

    // Receiver state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            div_lat <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            div_lat <= div_lat_n;
            bit_cnt <= bit_cnt_n;
            shreg   <= shreg_n;
        end
    end

    assign expire = (cnt == 16'd1);

    // Next-state logic. The first countdown is half a bit so that every
    // later expiry lands in the middle of a bit; the divisor is captured at
    // the start edge so a divisor change cannot disturb a frame in flight.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        div_lat_n = div_lat;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        push_req  = 1'b0;
        ferr_req  = 1'b0;
        case (state)
            IDLE: begin
                if (!line) begin
                    state_n   = START;
                    cnt_n     = baud_div >> 1;
                    div_lat_n = baud_div;
                end
            end
            START: begin
                if (!expire) begin
                    cnt_n = cnt - 16'd1;
                end else if (!line) begin
                    state_n   = DATA;
                    cnt_n     = div_lat;
                    bit_cnt_n = 3'd0;
                end else begin
                    state_n = IDLE;
                end
            end
            DATA: begin
                if (!expire) begin
                    cnt_n = cnt - 16'd1;
                end else begin
                    shreg_n   = {line, shreg[7:1]};
                    cnt_n     = div_lat;
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_n = STOP;
                    end
                end
            end
            STOP: begin
                if (!expire) begin
                    cnt_n = cnt - 16'd1;
                end else if (line) begin
                    push_req = 1'b1;
                    state_n  = IDLE;
                end else begin
                    ferr_req = 1'b1;
                    state_n  = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (line) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    // A pop in the same cycle frees the slot the push needs, so push+pop on
    // a full FIFO is accepted.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = rx_latch && !empty;
    assign push_ok = push_req && (!full || pop);
    assign ovr_req = push_req && full && !pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            frame_err <= ferr_req;
            overrun   <= ovr_req;
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= shreg;
        end
    end

    assign rx_valid = !empty;
    assign rx_data  = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo
// ---------------
// Self-checking bench for uart_rx_fifo. A behavioural model (byte queue plus
// a list of scheduled frame outcomes) predicts rx_valid, rx_data, frame_err
// and overrun; a compare process checks them on every falling clock edge.
// Directed scenarios pin the model with literal expectations; a randomized
// phase mixes frames, framing errors, divisor changes and random pops.

module tb_uart_rx_fifo;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] baud_div;
    logic        rx_in;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_latch;
    logic        frame_err;
    logic        overrun;

    uart_rx_fifo #(.FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .baud_div  (baud_div),
        .rx_in     (rx_in),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_latch  (rx_latch),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         edge_no;
        bit         ferr;
        logic [7:0] data;
    } ev_t;

    int         cyc = 0;
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] mq[$];
    ev_t        evq[$];
    bit         exp_ferr = 1'b0;
    bit         exp_ovr = 1'b0;
    int         latch_at = -1;
    bit         rand_pop_en = 1'b0;
    int         ferr_seen = 0;
    int         ovr_seen = 0;
    int         rise_cyc = -1;
    bit         prev_valid = 1'b0;
    int         t_fall = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: each frame resolves at the edge where the stop bit
    // is sampled; pops and pushes use the occupancy before that edge.
    always @(posedge clk) begin : model
        ev_t ev;
        bit  pop_ok;
        bit  do_push;
        cyc++;
        exp_ferr = 1'b0;
        exp_ovr  = 1'b0;
        if (reset) begin
            pop_ok  = rx_latch && (mq.size() > 0);
            do_push = 1'b0;
            if (evq.size() > 0 && evq[0].edge_no == cyc) begin
                ev = evq.pop_front();
                if (ev.ferr)
                    exp_ferr = 1'b1;
                else if (mq.size() == DEPTH && !pop_ok)
                    exp_ovr = 1'b1;
                else
                    do_push = 1'b1;
            end
            if (pop_ok)
                void'(mq.pop_front());
            if (do_push)
                mq.push_back(ev.data);
        end
    end

    // Compare process.
    always @(negedge clk) begin : compare
        logic [7:0] exp_data;
        exp_data = (mq.size() > 0) ? mq[0] : 8'h00;
        check("rx_valid", 16'(rx_valid), 16'(mq.size() > 0));
        check("rx_data", 16'(rx_data), 16'(exp_data));
        check("frame_err", 16'(frame_err), 16'(exp_ferr));
        check("overrun", 16'(overrun), 16'(exp_ovr));
        if (frame_err === 1'b1) ferr_seen++;
        if (overrun === 1'b1) ovr_seen++;
        if (rx_valid === 1'b1 && !prev_valid) rise_cyc = cyc;
        prev_valid = (rx_valid === 1'b1);
    end

    // Single driver of rx_latch: random pops or one pop at edge latch_at.
    initial begin
        rx_latch = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rand_pop_en)
                rx_latch = ($urandom_range(0, 3) == 0);
            else
                rx_latch = (latch_at == cyc + 1);
        end
    end

    // Send one frame. The outcome resolves at the stop-bit sample:
    // 2 synchronizer edges + 1 detect edge + half bit + 9 full bits.
    task automatic applyStimulus(input logic [7:0] data, input bit stop_bit, input int div,
                                 input int stop_len, input bit expect_ev, input bit chg_div);
        ev_t ev;
        baud_div = 16'(div);
        t_fall   = cyc;
        if (expect_ev) begin
            ev.edge_no = cyc + 3 + div / 2 + 9 * div;
            ev.ferr    = !stop_bit;
            ev.data    = data;
            evq.push_back(ev);
        end
        rx_in = 1'b0;
        repeat (div) tick();
        for (int i = 0; i < 8; i++) begin
            rx_in = data[i];
            if (chg_div && i == 3) baud_div = 16'($urandom_range(4, 300));
            repeat (div) tick();
        end
        rx_in = stop_bit;
        repeat (stop_len) tick();
        rx_in = 1'b1;
        if (!stop_bit) repeat (3) tick();
    endtask

    task automatic checkOutput(input logic [7:0] exp);
        check("pop data", 16'(rx_data), 16'(exp));
        latch_at = cyc + 2;
        repeat (2) tick();
    endtask

    initial begin
        int d;
        int base;
        reset    = 1'b1;
        rx_in    = 1'b1;
        baud_div = 16'd174;
        #1 reset = 1'b0;
        #1;
        check("reset rx_valid", 16'(rx_valid), 16'h0);
        check("reset rx_data", 16'(rx_data), 16'h0);
        check("reset frame_err", 16'(frame_err), 16'h0);
        check("reset overrun", 16'(overrun), 16'h0);
        repeat (3) tick();
        reset = 1'b1;
        repeat (3) tick();

        // Single byte with latency window.
        applyStimulus(8'hA5, 1'b1, 174, 174, 1'b1, 1'b0);
        d = rise_cyc - t_fall;
        check("A5 latency in window", 16'(d >= 1650 && d <= 1656), 16'h1);
        check("A5 model occupancy", 16'(mq.size()), 16'h1);
        checkOutput(8'hA5);
        check("A5 valid after pop", 16'(rx_valid), 16'h0);

        // False start followed by a good byte.
        rx_in = 1'b0;
        repeat (60) tick();
        rx_in = 1'b1;
        repeat (120) tick();
        check("false start no push", 16'(rx_valid), 16'h0);
        applyStimulus(8'h3C, 1'b1, 174, 174, 1'b1, 1'b0);
        checkOutput(8'h3C);

        // Framing error, then a good byte.
        base = ferr_seen;
        applyStimulus(8'h55, 1'b0, 174, 500, 1'b1, 1'b0);
        check("frame_err pulse count", 16'(ferr_seen - base), 16'h1);
        check("frame_err no push", 16'(rx_valid), 16'h0);
        applyStimulus(8'h01, 1'b1, 174, 174, 1'b1, 1'b0);
        checkOutput(8'h01);
        check("after 01 empty", 16'(rx_valid), 16'h0);

        // Overrun on the fifth back-to-back byte.
        base = ovr_seen;
        for (int b = 8'h10; b <= 8'h14; b++)
            applyStimulus(8'(b), 1'b1, 16, 16, 1'b1, 1'b0);
        check("overrun pulse count", 16'(ovr_seen - base), 16'h1);
        check("overrun model occupancy", 16'(mq.size()), 16'h4);
        for (int b = 8'h10; b <= 8'h13; b++)
            checkOutput(8'(b));
        check("overrun drained", 16'(rx_valid), 16'h0);

        // Push and pop on the same edge while full.
        for (int b = 8'h20; b <= 8'h23; b++)
            applyStimulus(8'(b), 1'b1, 16, 16, 1'b1, 1'b0);
        base = ovr_seen;
        latch_at = cyc + 3 + 8 + 9 * 16;
        applyStimulus(8'h99, 1'b1, 16, 16, 1'b1, 1'b0);
        check("simul no overrun", 16'(ovr_seen - base), 16'h0);
        check("simul model occupancy", 16'(mq.size()), 16'h4);
        checkOutput(8'h21);
        checkOutput(8'h22);
        checkOutput(8'h23);
        checkOutput(8'h99);
        check("simul drained", 16'(rx_valid), 16'h0);

        // Reset in the middle of data bit 4 of 0xF0, with a byte queued.
        applyStimulus(8'h77, 1'b1, 32, 32, 1'b1, 1'b0);
        baud_div = 16'd32;
        rx_in = 1'b0;
        repeat (32) tick();
        for (int i = 0; i < 4; i++) begin
            rx_in = (i >= 4);
            repeat (32) tick();
        end
        rx_in = 1'b1;
        repeat (16) tick();
        reset = 1'b0;
        mq.delete();
        evq.delete();
        exp_ferr = 1'b0;
        exp_ovr  = 1'b0;
        #1;
        check("midframe reset rx_valid", 16'(rx_valid), 16'h0);
        check("midframe reset rx_data", 16'(rx_data), 16'h0);
        check("midframe reset frame_err", 16'(frame_err), 16'h0);
        check("midframe reset overrun", 16'(overrun), 16'h0);
        repeat (5) tick();
        reset = 1'b1;
        repeat (400) tick();
        check("no stray byte", 16'(rx_valid), 16'h0);
        applyStimulus(8'h0F, 1'b1, 32, 32, 1'b1, 1'b0);
        checkOutput(8'h0F);
        check("after 0F empty", 16'(rx_valid), 16'h0);

        // Randomized frames with random pops, errors and divisor changes.
        rand_pop_en = 1'b1;
        for (int n = 0; n < 50; n++) begin
            int  div;
            bit  fe;
            div = $urandom_range(4, 20);
            fe  = ($urandom_range(0, 5) == 0);
            applyStimulus(8'($urandom_range(0, 255)), !fe, div,
                          fe ? div + $urandom_range(0, div) : div, 1'b1,
                          bit'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 5)) tick();
        end
        rand_pop_en = 1'b0;
        repeat (30) tick();
        for (int k = 0; k < 2 * DEPTH; k++) begin
            if (rx_valid) begin
                latch_at = cyc + 2;
                repeat (2) tick();
            end
        end
        check("random drained", 16'(rx_valid), 16'h0);
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
